// File: rtl/oh_csa_resolve_if.sv
// Handshake bundle for oh_csa_resolve: operand pair in, resolved sum out.
// The out_ovf signal exists only when CFG_CSA_RESOLVE_OVF_EN is defined.
interface oh_csa_resolve_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_s;
    logic [DW-1:0] in_c;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_sum;
`ifdef CFG_CSA_RESOLVE_OVF_EN
    logic          out_ovf;
`endif

    modport slave (
        input  in_valid, in_s, in_c, out_ready,
`ifdef CFG_CSA_RESOLVE_OVF_EN
        output out_ovf,
`endif
        output in_ready, out_valid, out_sum
    );

    modport master (
        output in_valid, in_s, in_c, out_ready,
`ifdef CFG_CSA_RESOLVE_OVF_EN
        input  out_ovf,
`endif
        input  in_ready, out_valid, out_sum
    );
endinterface

// File: rtl/oh_csa_resolve.sv
// Resolves a carry-save pair (s, c) into s + 2c, one CW-bit chunk per cycle, LSB first.
// Optional overflow flag enabled by defining CFG_CSA_RESOLVE_OVF_EN.
module oh_csa_resolve #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              nreset,
    oh_csa_resolve_if.slave   bus
);
    localparam int NCH = DW / CW;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [CW:0] chunk_add(
        input logic [CW-1:0] a,
        input logic [CW-1:0] b,
        input logic          cin
    );
        return {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
    endfunction

    state_t        state_r;
    logic [DW-1:0] opa_r;
    // Carry operand already shifted left; keeps bit DW so the overflow bit travels with it.
    logic [DW:0]   opb_r;
    logic [IW-1:0] idx_r;
    logic          carry_r;
    logic [DW-1:0] acc_r;
    logic [DW-1:0] out_sum_r;
    logic          in_ready_r;
    logic          out_valid_r;
`ifdef CFG_CSA_RESOLVE_OVF_EN
    logic          ovf_r;
`endif

    logic [CW:0]   csum_s;
    logic [DW-1:0] acc_next_s;

    // Chunk adder and accumulator shift: new chunk enters at the top of acc.
    always_comb begin
        csum_s     = {(CW+1){1'b0}};
        acc_next_s = {DW{1'b0}};
        csum_s     = chunk_add(opa_r[CW-1:0], opb_r[CW-1:0], carry_r);
        acc_next_s = (acc_r >> CW) | (DW'(csum_s[CW-1:0]) << (DW - CW));
    end

    // Control FSM with operand, accumulator and registered output state.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r     <= IDLE;
            opa_r       <= {DW{1'b0}};
            opb_r       <= {(DW+1){1'b0}};
            idx_r       <= {IW{1'b0}};
            carry_r     <= 1'b0;
            acc_r       <= {DW{1'b0}};
            out_sum_r   <= {DW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef CFG_CSA_RESOLVE_OVF_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        opa_r      <= bus.in_s;
                        opb_r      <= {bus.in_c, 1'b0};
                        idx_r      <= {IW{1'b0}};
                        carry_r    <= 1'b0;
                        acc_r      <= {DW{1'b0}};
                        in_ready_r <= 1'b0;
                        state_r    <= BUSY;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                BUSY: begin
                    opa_r   <= opa_r >> CW;
                    opb_r   <= opb_r >> CW;
                    carry_r <= csum_s[CW];
                    acc_r   <= acc_next_s;
                    if (idx_r == IW'(NCH - 1)) begin
                        idx_r       <= {IW{1'b0}};
                        out_sum_r   <= acc_next_s;
`ifdef CFG_CSA_RESOLVE_OVF_EN
                        // Original bit DW of (c << 1) sits at position CW on the final chunk.
                        ovf_r       <= csum_s[CW] | opb_r[CW];
`endif
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        idx_r   <= idx_r + IW'(1);
                        state_r <= BUSY;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_sum   = out_sum_r;
`ifdef CFG_CSA_RESOLVE_OVF_EN
    assign bus.out_ovf   = ovf_r;
`endif

endmodule

// File: tb/tb_oh_csa_resolve.sv
// Self-checking bench for oh_csa_resolve (DW=8, CW=4); checks out_ovf when CFG_CSA_RESOLVE_OVF_EN is defined.
module tb_oh_csa_resolve;
    logic clk;
    logic nreset;
    int   checks;
    int   failures;

    oh_csa_resolve_if #(.DW(8)) bus ();

    oh_csa_resolve #(.DW(8), .CW(4)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_sum(input int s, input int c);
        return 8'((s + 2 * c) % 256);
    endfunction

    function automatic logic ref_ovf(input int s, input int c);
        return ((s + 2 * c) > 255);
    endfunction

    // Present a pair, let it be accepted, scramble inputs, wait for out_valid.
    task automatic send_wait(input logic [7:0] s, input logic [7:0] c, output int lat);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_s     = s;
        bus.in_c     = c;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_s     = 8'($urandom);
        bus.in_c     = 8'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int lat;
    int sent;
    int got;
    int cyc;
    logic [7:0] rs;
    logic [7:0] rc;
    logic [7:0] exp_sum_q[$];
    logic       exp_ovf_q[$];
    logic [7:0] held;
    logic [7:0] e_sum;
    logic       e_ovf;

    initial begin
        checks        = 0;
        failures      = 0;
        nreset        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_s      = 8'h00;
        bus.in_c      = 8'h00;
        bus.out_ready = 1'b0;

        // Reset held three cycles
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum", 32'(bus.out_sum), 32'h00);
`ifdef CFG_CSA_RESOLVE_OVF_EN
        chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
`endif

        // Cross-chunk carry
        send_wait(8'h0F, 8'h01, lat);
        chk("lat_0f01", 32'(lat), 32'd2);
        chk("sum_0f01", 32'(bus.out_sum), 32'(ref_sum(8'h0F, 8'h01)));
        chk("sum_0f01_lit", 32'(bus.out_sum), 32'h11);
`ifdef CFG_CSA_RESOLVE_OVF_EN
        chk("ovf_0f01", 32'(bus.out_ovf), 32'd0);
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Overflowing pair
        send_wait(8'hFF, 8'h80, lat);
        chk("lat_ff80", 32'(lat), 32'd2);
        chk("sum_ff80", 32'(bus.out_sum), 32'hFF);
`ifdef CFG_CSA_RESOLVE_OVF_EN
        chk("ovf_ff80", 32'(bus.out_ovf), 32'd1);
`endif

        // Drain and new pair on the same edge: only the return to IDLE happens
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_s      = 8'h01;
        bus.in_c      = 8'h01;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("simul_in_ready", 32'(bus.in_ready), 32'd1);
        chk("simul_out_valid", 32'(bus.out_valid), 32'd0);
        chk("simul_retain", 32'(bus.out_sum), 32'hFF);
        @(negedge clk);
        chk("simul_no_accept", 32'(bus.in_ready), 32'd1);

        // Back-pressure hold with ignored in_valid pulses
        send_wait(8'h55, 8'h55, lat);
        chk("lat_5555", 32'(lat), 32'd2);
        held = bus.out_sum;
        chk("sum_5555", 32'(held), 32'hFF);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_s     = 8'($urandom);
            bus.in_c     = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_sum", 32'(bus.out_sum), 32'hFF);
            chk("hold_no_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("release_idle", 32'(bus.in_ready), 32'd1);
        chk("release_valid", 32'(bus.out_valid), 32'd0);
        chk("release_retain", 32'(bus.out_sum), 32'hFF);

        // Reset in BUSY abandons the operation
        bus.in_s     = 8'h12;
        bus.in_c     = 8'h34;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("busy_not_ready", 32'(bus.in_ready), 32'd0);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        chk("abort_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_sum", 32'(bus.out_sum), 32'h00);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) got++;
        end
        chk("abort_no_valid", 32'(got), 32'd0);

        // Random back-to-back pairs against the arithmetic model
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < 1000 || exp_sum_q.size() != 0) && cyc < 40000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_sum_q.size() == 0) begin
                    chk("rand_spurious", 32'd1, 32'd0);
                end else begin
                    e_sum = exp_sum_q.pop_front();
                    e_ovf = exp_ovf_q.pop_front();
                    chk("rand_sum", 32'(bus.out_sum), 32'(e_sum));
`ifdef CFG_CSA_RESOLVE_OVF_EN
                    chk("rand_ovf", 32'(bus.out_ovf), 32'(e_ovf));
`endif
                end
                got++;
            end
            rs = 8'($urandom);
            rc = 8'($urandom);
            bus.in_s     = rs;
            bus.in_c     = rc;
            bus.in_valid = (sent < 1000) && ($urandom_range(0, 4) != 0);
            if (bus.in_valid && bus.in_ready) begin
                exp_sum_q.push_back(ref_sum(int'(rs), int'(rc)));
                exp_ovf_q.push_back(ref_ovf(int'(rs), int'(rc)));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("rand_timeout", 32'(cyc < 40000), 32'd1);
        chk("rand_sent", 32'(sent), 32'd1000);
        chk("rand_count", 32'(got), 32'(sent));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
